bcd2bin: RTL and testbench



---
 rtl/bcd2bin.sv | 115 +++++++++++
 tb/tb_bcd2bin.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd2bin.sv
// Sequential BCD-to-binary converter: reverse double-dabble, one shift/correct step per clock.
// Optional BCD2BIN_CHECK_EN: invalid digits at acceptance finish at once with err=1, bin_out=0.
module bcd2bin #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned SrW  = BcdW + BIN_W;
  localparam int unsigned CntW = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(BIN_W - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e          state;
  logic [SrW-1:0]  sr;
  logic [SrW-1:0]  sr_step;
  logic [CntW-1:0] cnt;
  logic            bad_digit;

  // Shift right, then pull every BCD nibble that reached 8 or more back down by 3.
  always_comb begin
    sr_step = sr >> 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr_step[BIN_W + 4*i + 3]) begin
        sr_step[BIN_W + 4*i +: 4] = sr_step[BIN_W + 4*i +: 4] - 4'd3;
      end
    end
  end

`ifdef BCD2BIN_CHECK_EN
  logic err_q;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state == StIdle && in_valid) begin
      err_q <= bad_digit;
    end else if (state == StDone && out_ready) begin
      err_q <= 1'b0;
    end
  end

  assign err = err_q;
`else
  assign bad_digit = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      sr        <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      bin_out   <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            cnt      <= '0;
            if (bad_digit) begin
              sr        <= '0;
              bin_out   <= '0;
              out_valid <= 1'b1;
              state     <= StDone;
            end else begin
              sr    <= {bcd_in, {BIN_W{1'b0}}};
              state <= StShift;
            end
          end
        end
        StShift: begin
          sr <= sr_step;
          if (cnt == LastCnt) begin
            bin_out   <= sr_step[BIN_W-1:0];
            out_valid <= 1'b1;
            state     <= StDone;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StDone: begin
          // Result is held untouched until the consumer takes it.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin.sv
// Scoreboard bench for bcd2bin: decimal reference model, directed cases, sweep and random traffic.
module tb_bcd2bin;
  localparam int unsigned DIGITS = 3;
  localparam int unsigned BIN_W  = 10;
`ifdef BCD2BIN_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [4*DIGITS-1:0] bcd_in = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [BIN_W-1:0]    bin_out;
  logic                err;

  typedef struct {
    logic [BIN_W-1:0] bin;
    logic             err;
    int               lat;
    bit               chk_bin;
    int               acc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  bit   rand_ready = 1'b0;
  bit   ready_fix = 1'b1;

  bcd2bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .bcd_in   (bcd_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .bin_out  (bin_out),
    .err      (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fix;
  end

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Decimal value of the digits; invalid nibbles depend on whether checking is built.
  function automatic void ref_model(input logic [4*DIGITS-1:0] b, output exp_t e);
    int v = 0;
    bit bad = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      int d = int'(b[4*i +: 4]);
      if (d > 9) bad = 1'b1;
      v = v * 10 + d;
    end
    e.bin = BIN_W'(v);
    e.err = 1'b0;
    e.lat = BIN_W;
    e.chk_bin = 1'b1;
    e.acc = 0;
    if (bad) begin
      if (CHECK) begin
        e.bin = '0;
        e.err = 1'b1;
        e.lat = 1;
      end else begin
        e.chk_bin = 1'b0;
      end
    end
  endfunction

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] b = '0;
    int x = v;
    for (int i = 0; i < DIGITS; i++) begin
      b[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return b;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [4*DIGITS-1:0] b, output int acc);
    exp_t e;
    int   w = 0;
    in_valid = 1'b1;
    bcd_in   = b;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      check("accept_timeout", w, 0);
      acc = -1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    ref_model(b, e);
    e.acc = acc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    while (sb.size() != 0 && w < 1000) begin
      @(posedge clk);
      w++;
    end
    #1;
    check("drain", sb.size(), 0);
  endtask

  // Monitor: latency on out_valid rise, value on handshake, stability under back-pressure.
  logic             prev_wait = 1'b0;
  logic             prev_hs = 1'b0;
  logic             prev_valid = 1'b0;
  logic [BIN_W-1:0] prev_bin = '0;
  logic             prev_err = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (prev_hs) begin
        check("in_ready_after_hs", in_ready, 1);
        check("out_valid_after_hs", out_valid, 0);
      end
      if (prev_wait) begin
        check("hold_valid", out_valid, 1);
        check("hold_bin", bin_out, prev_bin);
        check("hold_err", err, prev_err);
        check("busy_in_ready", in_ready, 0);
      end
      if (out_valid && !prev_valid) begin
        if (sb.size() == 0) check("unexpected_out", sb.size(), 1);
        else check("latency", cyc - sb[0].acc, sb[0].lat);
      end
      if (out_valid && out_ready && sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk_bin) check("bin_out", bin_out, e.bin);
        check("err", err, e.err);
      end
    end
    prev_valid <= out_valid;
    prev_wait  <= rst_n && out_valid && !out_ready;
    prev_hs    <= rst_n && out_valid && out_ready;
    prev_bin   <= bin_out;
    prev_err   <= err;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0, a1, a2, w;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_bin_out", bin_out, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(12'h999, a0);
    wait_idle();

    send(12'h000, a0);
    send(12'h255, a1);
    send(12'h010, a2);
    check("period_1", a1 - a0, BIN_W + 2);
    check("period_2", a2 - a1, BIN_W + 2);
    wait_idle();

    // Back-pressure with a stray in_valid pulse while the result is held.
    ready_fix = 1'b0;
    @(posedge clk);
    #1;
    send(12'h473, a0);
    w = 0;
    while (!out_valid && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("bp_out_valid", out_valid, 1);
    in_valid = 1'b1;
    bcd_in   = 12'h999;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("bp_bin_out", bin_out, 473);
    check("bp_in_ready", in_ready, 0);
    ready_fix = 1'b1;
    wait_idle();

    // Reset in the middle of a conversion.
    in_valid = 1'b1;
    bcd_in   = 12'h123;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_bin_out", bin_out, 0);
    check("mid_rst_err", err, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(12'h042, a0);
    wait_idle();

    send(12'h1A3, a0);
    wait_idle();

    for (int v = 0; v < 1000; v++) send(to_bcd(v), a0);
    wait_idle();

    rand_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      logic [4*DIGITS-1:0] b;
      for (int i = 0; i < DIGITS; i++) begin
        b[4*i +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                  : 4'($urandom_range(0, 9));
      end
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      send(b, a0);
    end
    rand_ready = 1'b0;
    wait_idle();

    repeat (20) @(posedge clk);
    #1;
    check("final_queue", sb.size(), 0);
    check("final_out_valid", out_valid, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
